// File: rtl/mix_round_engine_pkg.sv
// Shared types, defaults and the word-mixing function for mix_round_engine.
package mix_pkg;

  localparam int          DEF_WORD_W    = 32;
  localparam int          DEF_NUM_WORDS = 20;
  localparam int unsigned MAX_WORD_W    = 64;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  // Words of up to MAX_WORD_W bits travel zero-extended in a 64-bit container.
  function automatic logic [MAX_WORD_W-1:0] mix(input logic [MAX_WORD_W-1:0] w,
                                                input int unsigned width,
                                                input int unsigned rot_a,
                                                input int unsigned rot_b,
                                                input int unsigned shr);
    logic [MAX_WORD_W-1:0] mask;
    logic [MAX_WORD_W-1:0] wm;
    logic [MAX_WORD_W-1:0] ra;
    logic [MAX_WORD_W-1:0] rb;
    mask = (width >= MAX_WORD_W) ? '1 : ((64'd1 << width) - 64'd1);
    wm   = w & mask;
    ra   = ((wm << rot_a) | (wm >> (width - rot_a))) & mask;
    rb   = ((wm << rot_b) | (wm >> (width - rot_b))) & mask;
    return (ra ^ rb ^ (wm >> shr)) & mask;
  endfunction

endpackage

// File: rtl/mix_round_engine_if.sv
// Upstream/downstream valid-ready bundle for mix_round_engine.
interface mix_round_engine_if
  import mix_pkg::*;
#(
  parameter int S = DEF_WORD_W * DEF_NUM_WORDS
);
  logic         in_valid;
  logic         in_ready;
  logic [S-1:0] in_data;
  logic [7:0]   in_rounds;
  logic         out_valid;
  logic         out_ready;
  logic [S-1:0] out_data;

  modport master (
    output in_valid, in_data, in_rounds, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_rounds, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/mix_round_engine_lane.sv
// One lane: mix(w) ^ neighbour, with the round constant folded in when rc_en is set.
module mix_lane
  import mix_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int ROT_A  = 7,
  parameter int ROT_B  = 18,
  parameter int SHR    = 3
) (
  input  logic [WORD_W-1:0] w,
  input  logic [WORD_W-1:0] nb,
  input  logic [WORD_W-1:0] rc,
  input  logic              rc_en,
  output logic [WORD_W-1:0] y
);

  always_comb begin
    y = WORD_W'(mix(MAX_WORD_W'(w), WORD_W, ROT_A, ROT_B, SHR)) ^ nb ^ (rc_en ? rc : '0);
  end

endmodule

// File: rtl/mix_round_engine.sv
// Iterative word-mixing engine: LANES words per cycle, runtime round count.
//   state | meaning
//   IDLE  | in_ready high, waiting for a state + round count
//   BUSY  | one chunk of LANES words updated per cycle
//   DONE  | out_valid high, result held until out_ready
module mix_round_engine
  import mix_pkg::*;
#(
  parameter int WORD_W    = DEF_WORD_W,
  parameter int NUM_WORDS = DEF_NUM_WORDS,
  parameter int LANES     = 4,
  parameter int ROT_A     = 7,
  parameter int ROT_B     = 18,
  parameter int SHR       = 3
) (
  input logic               clk,
  input logic               rst_n,
  mix_round_engine_if.slave bus
);

  localparam int S      = WORD_W * NUM_WORDS;
  localparam int CHUNKS = NUM_WORDS / LANES;
  localparam int KW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(CHUNKS - 1);

  state_t            state_q, state_d;
  logic [S-1:0]      data_q, data_d;
  logic [WORD_W-1:0] w0_save_q, w0_save_d;
  logic [7:0]        rounds_q, rounds_d;
  logic [7:0]        r_q, r_d;
  logic [KW-1:0]     k_q, k_d;

  logic [WORD_W-1:0] rc;
  logic [WORD_W-1:0] lane_w  [LANES];
  logic [WORD_W-1:0] lane_nb [LANES];
  logic [WORD_W-1:0] lane_y  [LANES];
  logic [LANES-1:0]  lane_rc_en;

  assign rc           = WORD_W'({1'b0, r_q} + 9'd1);
  assign bus.out_data = data_q;

  // Word 0 is already overwritten when the last chunk needs it, so use the saved copy.
  always_comb begin
    int idx;
    idx = 0;
    for (int j = 0; j < LANES; j++) begin
      idx           = int'(k_q) * LANES + j;
      lane_w[j]     = data_q[idx*WORD_W +: WORD_W];
      lane_rc_en[j] = (idx == 0);
      if (idx == NUM_WORDS - 1) begin
        lane_nb[j] = (CHUNKS == 1) ? data_q[WORD_W-1:0] : w0_save_q;
      end else begin
        lane_nb[j] = data_q[(idx+1)*WORD_W +: WORD_W];
      end
    end
  end

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    mix_lane #(
      .WORD_W (WORD_W),
      .ROT_A  (ROT_A),
      .ROT_B  (ROT_B),
      .SHR    (SHR)
    ) u_lane (
      .w     (lane_w[j]),
      .nb    (lane_nb[j]),
      .rc    (rc),
      .rc_en (lane_rc_en[j]),
      .y     (lane_y[j])
    );
  end

  always_comb begin
    int base;
    state_d       = state_q;
    data_d        = data_q;
    w0_save_d     = w0_save_q;
    rounds_d      = rounds_q;
    r_d           = r_q;
    k_d           = k_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    base          = int'(k_q) * LANES;

    unique case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          data_d   = bus.in_data;
          rounds_d = bus.in_rounds;
          r_d      = '0;
          k_d      = '0;
          state_d  = (bus.in_rounds == 8'd0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        for (int j = 0; j < LANES; j++) begin
          data_d[(base+j)*WORD_W +: WORD_W] = lane_y[j];
        end
        if (k_q == '0) begin
          w0_save_d = data_q[WORD_W-1:0];
        end
        if (k_q == K_LAST) begin
          k_d = '0;
          r_d = r_q + 8'd1;
          if (r_q == rounds_q - 8'd1) begin
            state_d = DONE;
          end
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      data_q    <= '0;
      w0_save_q <= '0;
      rounds_q  <= '0;
      r_q       <= '0;
      k_q       <= '0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      w0_save_q <= w0_save_d;
      rounds_q  <= rounds_d;
      r_q       <= r_d;
      k_q       <= k_d;
    end
  end

endmodule

// File: tb/tb_mix_round_engine.sv
// Directed bench for mix_round_engine; four builds with LANES = 4, 1, 20, 5.
module tb_mix_round_engine;

  localparam int S = 640;

  logic clk = 1'b0;
  logic rst_n;
  logic aux_valid;
  logic aux_ready;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mix_round_engine_if #(.S(S)) bus4 (), bus1 (), bus20 (), bus5 ();

  assign bus1.in_valid   = aux_valid;
  assign bus20.in_valid  = aux_valid;
  assign bus5.in_valid   = aux_valid;
  assign bus1.out_ready  = aux_ready;
  assign bus20.out_ready = aux_ready;
  assign bus5.out_ready  = aux_ready;
  assign bus1.in_data    = bus4.in_data;
  assign bus20.in_data   = bus4.in_data;
  assign bus5.in_data    = bus4.in_data;
  assign bus1.in_rounds  = bus4.in_rounds;
  assign bus20.in_rounds = bus4.in_rounds;
  assign bus5.in_rounds  = bus4.in_rounds;

  mix_round_engine #(.WORD_W(32), .NUM_WORDS(20), .LANES(4), .ROT_A(7), .ROT_B(18), .SHR(3))
    dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  mix_round_engine #(.WORD_W(32), .NUM_WORDS(20), .LANES(1), .ROT_A(7), .ROT_B(18), .SHR(3))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  mix_round_engine #(.WORD_W(32), .NUM_WORDS(20), .LANES(20), .ROT_A(7), .ROT_B(18), .SHR(3))
    dut20 (.clk(clk), .rst_n(rst_n), .bus(bus20));
  mix_round_engine #(.WORD_W(32), .NUM_WORDS(20), .LANES(5), .ROT_A(7), .ROT_B(18), .SHR(3))
    dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5));

  function automatic logic [31:0] ref_word(input logic [31:0] w);
    return {w[24:0], w[31:25]} ^ {w[13:0], w[31:14]} ^ (w >> 3);
  endfunction

  // Whole-state reference: every round reads a snapshot of the previous round.
  function automatic logic [S-1:0] ref_state(input logic [S-1:0] st, input int n);
    logic [31:0]  o  [20];
    logic [31:0]  nw [20];
    logic [S-1:0] res;
    for (int i = 0; i < 20; i++) o[i] = st[32*i +: 32];
    for (int r = 0; r < n; r++) begin
      for (int i = 0; i < 20; i++) nw[i] = ref_word(o[i]) ^ o[(i+1) % 20];
      nw[0] = nw[0] ^ 32'(r + 1);
      o = nw;
    end
    for (int i = 0; i < 20; i++) res[32*i +: 32] = o[i];
    return res;
  endfunction

  function automatic logic [S-1:0] rand_state();
    logic [S-1:0] v;
    for (int i = 0; i < 20; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic check(input string tag, input logic [S-1:0] obs, input logic [S-1:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      failed = failed + 1;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    check(tag, S'(obs), S'(exp));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [S-1:0] d, input logic [7:0] n);
    check_bit("send_in_ready", bus4.in_ready, 1'b1);
    bus4.in_data   = d;
    bus4.in_rounds = n;
    bus4.in_valid  = 1'b1;
    step();
    bus4.in_valid  = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int exp_lat);
    int cnt = 0;
    while (bus4.out_valid !== 1'b1 && cnt < 200) begin
      step();
      cnt++;
    end
    check(tag, S'(cnt), S'(exp_lat));
  endtask

  task automatic take(input string tag);
    bus4.out_ready = 1'b1;
    step();
    bus4.out_ready = 1'b0;
    check_bit({tag, "_in_ready"}, bus4.in_ready, 1'b1);
    check_bit({tag, "_out_valid"}, bus4.out_valid, 1'b0);
  endtask

  initial begin
    logic [S-1:0] v;
    logic [S-1:0] v2;
    logic [S-1:0] e;
    int l4, l1, l20, l5;

    rst_n          = 1'b0;
    aux_valid      = 1'b0;
    aux_ready      = 1'b0;
    bus4.in_valid  = 1'b1;
    bus4.in_data   = '1;
    bus4.in_rounds = 8'd0;
    bus4.out_ready = 1'b0;
    repeat (3) step();
    check_bit("rst_in_ready", bus4.in_ready, 1'b1);
    check_bit("rst_out_valid", bus4.out_valid, 1'b0);
    check("rst_out_data", bus4.out_data, '0);
    bus4.in_valid = 1'b0;
    rst_n = 1'b1;
    step();
    check_bit("post_rst_out_valid", bus4.out_valid, 1'b0);
    check("post_rst_out_data", bus4.out_data, '0);

    // All-zero state, one round: only the round constant appears in word 0.
    send('0, 8'd1);
    wait_valid("zero_r1_latency", 5);
    check("zero_r1_data", bus4.out_data, S'(1));
    take("zero_r1");

    // Single bit in word 1: word 0 cancels against the constant.
    v = '0;
    v[63:32] = 32'h0000_0001;
    e = '0;
    e[63:32] = 32'h0004_0080;
    send(v, 8'd1);
    wait_valid("bit1_latency", 5);
    check("bit1_data", bus4.out_data, e);
    take("bit1");

    v = rand_state();
    send(v, 8'd0);
    wait_valid("pass_latency", 0);
    check("pass_data", bus4.out_data, v);
    take("pass");

    // Backpressure with ignored in_valid pulses during BUSY and DONE.
    v = rand_state();
    e = ref_state(v, 3);
    send(v, 8'd3);
    for (int i = 0; i < 4; i++) begin
      check_bit("busy_in_ready", bus4.in_ready, 1'b0);
      bus4.in_valid = 1'b1;
      bus4.in_data  = ~v;
      step();
    end
    bus4.in_valid = 1'b0;
    wait_valid("hold_latency", 11);
    for (int i = 0; i < 10; i++) begin
      check("hold_data", bus4.out_data, e);
      check_bit("hold_out_valid", bus4.out_valid, 1'b1);
      check_bit("hold_in_ready", bus4.in_ready, 1'b0);
      bus4.in_valid = (i % 2 == 0);
      bus4.in_data  = ~v;
      step();
    end
    bus4.in_valid = 1'b0;
    take("hold");
    check("hold_not_latched", bus4.out_data, e);

    // Asynchronous reset in the middle of BUSY.
    v = rand_state();
    send(v, 8'd3);
    repeat (7) step();
    #2 rst_n = 1'b0;
    #1;
    check_bit("midrst_out_valid", bus4.out_valid, 1'b0);
    check("midrst_out_data", bus4.out_data, '0);
    check_bit("midrst_in_ready", bus4.in_ready, 1'b1);
    #1 rst_n = 1'b1;
    step();
    check_bit("after_rst_out_valid", bus4.out_valid, 1'b0);
    v2 = rand_state();
    send(v2, 8'd2);
    wait_valid("after_rst_latency", 10);
    check("after_rst_data", bus4.out_data, ref_state(v2, 2));
    take("after_rst");

    // Same vector into all four lane builds at once.
    v = rand_state();
    e = ref_state(v, 2);
    bus4.in_data   = v;
    bus4.in_rounds = 8'd2;
    bus4.in_valid  = 1'b1;
    aux_valid      = 1'b1;
    step();
    bus4.in_valid  = 1'b0;
    aux_valid      = 1'b0;
    l4 = -1; l1 = -1; l20 = -1; l5 = -1;
    for (int c = 0; c < 60; c++) begin
      if (l4  < 0 && bus4.out_valid  === 1'b1) l4  = c;
      if (l1  < 0 && bus1.out_valid  === 1'b1) l1  = c;
      if (l20 < 0 && bus20.out_valid === 1'b1) l20 = c;
      if (l5  < 0 && bus5.out_valid  === 1'b1) l5  = c;
      step();
    end
    check("lanes4_latency", S'(l4), S'(10));
    check("lanes1_latency", S'(l1), S'(40));
    check("lanes20_latency", S'(l20), S'(2));
    check("lanes5_latency", S'(l5), S'(8));
    check("lanes4_data", bus4.out_data, e);
    check("lanes1_data", bus1.out_data, e);
    check("lanes20_data", bus20.out_data, e);
    check("lanes5_data", bus5.out_data, e);
    aux_ready = 1'b1;
    take("lanes4");
    aux_ready = 1'b0;
    check_bit("lanes1_in_ready", bus1.in_ready, 1'b1);
    check_bit("lanes20_in_ready", bus20.in_ready, 1'b1);
    check_bit("lanes5_in_ready", bus5.in_ready, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
